// File: rtl/ir_packet_tx_if.sv
// ir_packet_tx_if: command/handshake bundle between the command logic and
// the IR packet transmitter. The master drives requests, the slave (the
// transmitter) returns the LED, status pulses and car indicator.
interface ir_packet_tx_if #(
  parameter int CAR_COUNT = 4,
  parameter int CMD_LEN   = 4
);
  localparam int SEL_W = $clog2(CAR_COUNT);

  logic [CMD_LEN-1:0]   command;
  logic [SEL_W-1:0]     car_sel;
  logic                 send_packet;
  logic                 repeat_en;
  logic                 ir_led;
  logic                 busy;
  logic                 done;
  logic                 reject;
  logic [CAR_COUNT-1:0] car_led;

  modport master (
    output command, car_sel, send_packet, repeat_en,
    input  ir_led, busy, done, reject, car_led
  );

  modport slave (
    input  command, car_sel, send_packet, repeat_en,
    output ir_led, busy, done, reject, car_led
  );
endinterface

// File: rtl/ir_packet_tx.sv
// ir_packet_tx: per-car IR packet transmitter. A packet is
// START, gap, SELECT, gap, then every command bit (MSB first) followed by a
// gap. Burst phases are modulated by a carrier whose period comes from the
// latched car's table entry. Tables are packed with car 0 in the LSB slice.
module ir_packet_tx #(
  parameter int CAR_COUNT = 4,
  parameter int CMD_LEN   = 4,
  parameter int CNT_W     = 16,
  parameter logic [CAR_COUNT*CNT_W-1:0] CARRIER_PERIOD  = {16'd2778, 16'd2500, 16'd2667, 16'd2778},
  parameter logic [CAR_COUNT*CNT_W-1:0] START_PULSES    = {16'd191, 16'd88, 16'd88, 16'd192},
  parameter logic [CAR_COUNT*CNT_W-1:0] SELECT_PULSES   = {16'd47, 16'd22, 16'd44, 16'd24},
  parameter logic [CAR_COUNT*CNT_W-1:0] GAP_PULSES      = {16'd25, 16'd40, 16'd40, 16'd24},
  parameter logic [CAR_COUNT*CNT_W-1:0] ASSERT_PULSES   = {16'd47, 16'd44, 16'd44, 16'd48},
  parameter logic [CAR_COUNT*CNT_W-1:0] DEASSERT_PULSES = {16'd22, 16'd22, 16'd22, 16'd24},
  parameter logic [31:0] REPEAT_PERIOD = 32'd10_000_000
) (
  input logic clk,
  input logic rst,
  ir_packet_tx_if.slave bus
);

  localparam int SEL_W = $clog2(CAR_COUNT);
  localparam int BIT_W = (CMD_LEN > 1) ? $clog2(CMD_LEN) : 1;
  localparam logic [CNT_W-1:0]     ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     ONE      = CNT_W'(1'b1);
  localparam logic [BIT_W-1:0]     BIT_TOP  = BIT_W'(CMD_LEN - 1);
  localparam logic [CAR_COUNT-1:0] LED_ONE  = CAR_COUNT'(1'b1);
  localparam logic [31:0]          RPT_LAST = REPEAT_PERIOD - 32'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    GAP_S   = 3'd2,
    SELECT  = 3'd3,
    GAP_C   = 3'd4,
    BIT     = 3'd5,
    BIT_GAP = 3'd6
  } state_t;

  // Table lookup by car index; an out-of-range index yields zero.
  function automatic logic [CNT_W-1:0] pick(input logic [CAR_COUNT*CNT_W-1:0] tbl,
                                            input logic [SEL_W-1:0] idx);
    logic [CNT_W-1:0] val;
    val = ZERO;
    for (int i = 0; i < CAR_COUNT; i++) begin
      if (idx == SEL_W'(i)) val = tbl[i*CNT_W +: CNT_W];
    end
    return val;
  endfunction

  function automatic logic is_burst(input state_t s);
    return (s == START) || (s == SELECT) || (s == BIT);
  endfunction

  state_t               state, state_next;
  logic [CNT_W-1:0]     period, n_start, n_select, n_gap, n_assert, n_deassert;
  logic [CMD_LEN-1:0]   cmd;
  logic [BIT_W-1:0]     bit_idx, bit_next;
  logic [CNT_W-1:0]     car_cnt, pul_cnt, car_next, pul_next, phase_len, sel_period;
  logic [31:0]          rpt_timer;
  logic                 pending;
  logic                 car_wrap, phase_end, req, auto_req, car_bad;
  logic                 ir_led, busy, done, reject;
  logic [CAR_COUNT-1:0] car_led;

  assign bus.ir_led  = ir_led;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.reject  = reject;
  assign bus.car_led = car_led;

  // Phase length, carrier/pulse counter advance and next phase selection.
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    case (state)
      START:                 phase_len = n_start;
      SELECT:                phase_len = n_select;
      BIT:                   phase_len = cmd[bit_idx] ? n_assert : n_deassert;
      GAP_S, GAP_C, BIT_GAP: phase_len = n_gap;
      default:               phase_len = n_gap;
    endcase
    car_wrap  = (car_cnt == period - ONE);
    phase_end = car_wrap && (pul_cnt == phase_len - ONE);
    car_next  = car_wrap ? ZERO : car_cnt + ONE;
    if (car_wrap) begin
      pul_next = phase_end ? ZERO : pul_cnt + ONE;
    end else begin
      pul_next = pul_cnt;
    end
    if (phase_end) begin
      case (state)
        START:  state_next = GAP_S;
        GAP_S:  state_next = SELECT;
        SELECT: state_next = GAP_C;
        GAP_C:  state_next = BIT;
        BIT:    state_next = BIT_GAP;
        BIT_GAP: begin
          if (bit_idx == {BIT_W{1'b0}}) begin
            state_next = IDLE;
          end else begin
            state_next = BIT;
            bit_next   = bit_idx - BIT_W'(1'b1);
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
    req        = pending || bus.send_packet;
    auto_req   = bus.repeat_en && (rpt_timer == RPT_LAST);
    car_bad    = ({1'b0, bus.car_sel} >= (SEL_W + 1)'(CAR_COUNT));
    sel_period = pick(CARRIER_PERIOD, bus.car_sel);
  end

  // Packet FSM with start arbitration, pending flag, repeat timer and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period     <= ZERO;
      n_start    <= ZERO;
      n_select   <= ZERO;
      n_gap      <= ZERO;
      n_assert   <= ZERO;
      n_deassert <= ZERO;
      cmd        <= {CMD_LEN{1'b0}};
      bit_idx    <= {BIT_W{1'b0}};
      car_cnt    <= ZERO;
      pul_cnt    <= ZERO;
      rpt_timer  <= 32'd0;
      pending    <= 1'b0;
      ir_led     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject     <= 1'b0;
      car_led    <= {CAR_COUNT{1'b0}};
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      if (rpt_timer != RPT_LAST) rpt_timer <= rpt_timer + 32'd1;
      if (state == IDLE) begin
        if (done) begin
          // No start in the DONE cycle; a request seen here is kept.
          if (bus.send_packet) pending <= 1'b1;
        end else if (req || auto_req) begin
          pending   <= 1'b0;
          // Restarting the timer on a refusal too keeps a bad index under
          // auto-repeat from pulsing REJECT every cycle.
          rpt_timer <= 32'd0;
          if (car_bad) begin
            reject <= 1'b1;
          end else begin
            state      <= START;
            period     <= sel_period;
            n_start    <= pick(START_PULSES, bus.car_sel);
            n_select   <= pick(SELECT_PULSES, bus.car_sel);
            n_gap      <= pick(GAP_PULSES, bus.car_sel);
            n_assert   <= pick(ASSERT_PULSES, bus.car_sel);
            n_deassert <= pick(DEASSERT_PULSES, bus.car_sel);
            cmd        <= bus.command;
            bit_idx    <= BIT_TOP;
            car_cnt    <= ZERO;
            pul_cnt    <= ZERO;
            busy       <= 1'b1;
            ir_led     <= (ZERO < (sel_period >> 1'b1));
            car_led    <= LED_ONE << bus.car_sel;
          end
        end
      end else begin
        if (bus.send_packet) pending <= 1'b1;
        state   <= state_next;
        car_cnt <= car_next;
        pul_cnt <= pul_next;
        bit_idx <= bit_next;
        ir_led  <= is_burst(state_next) && (car_next < (period >> 1'b1));
        if (state_next == IDLE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed bench for ir_packet_tx using shrunken timing tables so every
// scenario completes in a few hundred cycles.
module tb_ir_packet_tx;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ir_packet_tx_if #(.CAR_COUNT(4), .CMD_LEN(4)) bus1 ();
  ir_packet_tx_if #(.CAR_COUNT(3), .CMD_LEN(4)) bus2 ();

  ir_packet_tx #(
    .CAR_COUNT(4), .CMD_LEN(4), .CNT_W(16),
    .CARRIER_PERIOD ({16'd7, 16'd4, 16'd5, 16'd6}),
    .START_PULSES   ({16'd5, 16'd2, 16'd4, 16'd3}),
    .SELECT_PULSES  ({16'd3, 16'd2, 16'd3, 16'd2}),
    .GAP_PULSES     ({16'd2, 16'd1, 16'd2, 16'd1}),
    .ASSERT_PULSES  ({16'd4, 16'd3, 16'd3, 16'd3}),
    .DEASSERT_PULSES({16'd2, 16'd2, 16'd1, 16'd1}),
    .REPEAT_PERIOD  (32'd100)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  ir_packet_tx #(
    .CAR_COUNT(3), .CMD_LEN(4), .CNT_W(16),
    .CARRIER_PERIOD ({16'd4, 16'd4, 16'd4}),
    .START_PULSES   ({16'd1, 16'd1, 16'd1}),
    .SELECT_PULSES  ({16'd1, 16'd1, 16'd1}),
    .GAP_PULSES     ({16'd1, 16'd1, 16'd1}),
    .ASSERT_PULSES  ({16'd2, 16'd2, 16'd2}),
    .DEASSERT_PULSES({16'd1, 16'd1, 16'd1}),
    .REPEAT_PERIOD  (32'd100000)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Car tables of dut1, indexed by car number.
  int PT [4] = '{6, 5, 4, 7};
  int ST [4] = '{3, 4, 2, 5};
  int SE [4] = '{2, 3, 2, 3};
  int GP [4] = '{1, 2, 1, 2};
  int AS [4] = '{3, 3, 3, 4};
  int DE [4] = '{1, 1, 2, 2};

  function automatic int model_len(int car, logic [3:0] cmd);
    int pulses;
    pulses = ST[car] + SE[car] + 2 * GP[car];
    for (int b = 0; b < 4; b++) pulses += (cmd[b] ? AS[car] : DE[car]) + GP[car];
    return pulses * PT[car];
  endfunction

  // Expected LED level r cycles into a packet, from the phase list.
  function automatic logic model_bit(int car, logic [3:0] cmd, int r);
    int lens [12];
    bit bur [12];
    int p, pulse, c;
    p = PT[car];
    pulse = r / p;
    c = r % p;
    lens[0] = ST[car]; bur[0] = 1'b1;
    lens[1] = GP[car]; bur[1] = 1'b0;
    lens[2] = SE[car]; bur[2] = 1'b1;
    lens[3] = GP[car]; bur[3] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      lens[4 + 2*b] = cmd[3 - b] ? AS[car] : DE[car];
      bur[4 + 2*b]  = 1'b1;
      lens[5 + 2*b] = GP[car];
      bur[5 + 2*b]  = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      if (pulse < lens[i]) return bur[i] && (c < p / 2);
      pulse -= lens[i];
    end
    return 1'b0;
  endfunction

  function automatic logic [511:0] model_wave(int car, logic [3:0] cmd);
    logic [511:0] w;
    int n;
    w = '0;
    n = model_len(car, cmd);
    for (int r = 0; r < n && r < 512; r++) w[r] = model_bit(car, cmd, r);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_one1(input int car, input logic [3:0] cmd);
    bus1.car_sel     = 2'(car);
    bus1.command     = cmd;
    bus1.send_packet = 1'b1;
    step();
    bus1.send_packet = 1'b0;
  endtask

  // Records dut1's packet from its first busy cycle until DONE is seen.
  task automatic capture(output int len, output int rises, output logic [511:0] wave,
                         output bit timed_out);
    logic prev;
    len = 0; rises = 0; wave = '0; timed_out = 1'b1; prev = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus1.done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus1.busy) len++;
      if (i < 512) wave[i] = bus1.ir_led;
      if (bus1.ir_led && !prev) rises++;
      prev = bus1.ir_led;
      step();
    end
  endtask

  task automatic next_start(output int t, output bit to);
    int guard;
    guard = 0;
    while (bus1.busy && guard < 1000) begin step(); guard++; end
    while (!bus1.busy && guard < 1000) begin step(); guard++; end
    to = (guard >= 1000);
    t = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus1.ir_led, bus1.busy, bus1.done, bus1.reject} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_status1: got %b expected 0000", {bus1.ir_led, bus1.busy, bus1.done, bus1.reject});
    end
    tests++;
    if (bus1.car_led !== 4'b0000) begin
      fails++;
      $display("FAIL reset_car_led: got %b expected 0000", bus1.car_led);
    end
    tests++;
    if ({bus2.ir_led, bus2.busy, bus2.done, bus2.reject, bus2.car_led} !== 7'b0) begin
      fails++;
      $display("FAIL reset_status2: got %b expected 0000000",
               {bus2.ir_led, bus2.busy, bus2.done, bus2.reject, bus2.car_led});
    end
  endtask

  task automatic test_single_packet();
    int len, rises;
    logic [511:0] wave;
    bit to;
    do_reset();
    send_one1(3, 4'b0101);
    tests++;
    if ({bus1.busy, bus1.ir_led} !== 2'b11) begin
      fails++;
      $display("FAIL single_start: busy,ir got %b expected 11", {bus1.busy, bus1.ir_led});
    end
    tests++;
    if (bus1.car_led !== 4'b1000) begin
      fails++;
      $display("FAIL single_car_led: got %b expected 1000", bus1.car_led);
    end
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 224) begin
      fails++;
      $display("FAIL single_len: got %0d (timeout %0d) expected 224", len, to);
    end
    tests++;
    if (rises !== 20) begin
      fails++;
      $display("FAIL single_rises: got %0d expected 20", rises);
    end
    tests++;
    if (wave !== model_wave(3, 4'b0101)) begin
      fails++;
      $display("FAIL single_wave: got %h expected %h", wave, model_wave(3, 4'b0101));
    end
    tests++;
    if ({bus1.done, bus1.busy} !== 2'b10) begin
      fails++;
      $display("FAIL single_done_cycle: done,busy got %b expected 10", {bus1.done, bus1.busy});
    end
    step();
    tests++;
    if (bus1.done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_width: got %b expected 0", bus1.done);
    end
  endtask

  task automatic test_carrier_shape();
    int len, rises;
    logic [511:0] wave;
    bit to;
    do_reset();
    send_one1(2, 4'b1000);
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 76) begin
      fails++;
      $display("FAIL carrier_len: got %0d (timeout %0d) expected 76", len, to);
    end
    tests++;
    if (wave[7:0] !== 8'b0011_0011) begin
      fails++;
      $display("FAIL carrier_start_burst: got %b expected 00110011", wave[7:0]);
    end
    tests++;
    if (wave[11:8] !== 4'b0000) begin
      fails++;
      $display("FAIL carrier_gap: got %b expected 0000", wave[11:8]);
    end
    tests++;
    if (wave !== model_wave(2, 4'b1000)) begin
      fails++;
      $display("FAIL carrier_wave: got %h expected %h", wave, model_wave(2, 4'b1000));
    end
  endtask

  task automatic test_pending_collapse();
    int len, rises, extra;
    logic [511:0] wave;
    bit to;
    do_reset();
    send_one1(0, 4'b0101);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus1.done) begin
        to = 1'b0;
        break;
      end
      bus1.send_packet = (i == 10 || i == 20 || i == 30);
      if (i == 80) bus1.command = 4'b1010;
      step();
    end
    bus1.send_packet = 1'b0;
    tests++;
    if (to) begin
      fails++;
      $display("FAIL pend_first_done: timeout got 1 expected 0");
    end
    step();
    tests++;
    if (bus1.busy !== 1'b0) begin
      fails++;
      $display("FAIL pend_start_cycle: busy got %b expected 0", bus1.busy);
    end
    step();
    tests++;
    if (bus1.busy !== 1'b1) begin
      fails++;
      $display("FAIL pend_restart: busy got %b expected 1", bus1.busy);
    end
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 114) begin
      fails++;
      $display("FAIL pend_len: got %0d (timeout %0d) expected 114", len, to);
    end
    tests++;
    if (wave !== model_wave(0, 4'b1010)) begin
      fails++;
      $display("FAIL pend_wave: got %h expected %h", wave, model_wave(0, 4'b1010));
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus1.busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL pend_single_extra: busy cycles got %0d expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int len, rises, idle;
    logic [511:0] wave;
    bit to;
    do_reset();
    bus1.car_sel = 2'd0;
    bus1.command = 4'b0000;
    bus1.send_packet = 1'b1;
    step();
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 90) begin
      fails++;
      $display("FAIL b2b_len1: got %0d (timeout %0d) expected 90", len, to);
    end
    idle = 0;
    while (!bus1.busy && idle < 10) begin
      idle++;
      step();
    end
    tests++;
    if (idle !== 2) begin
      fails++;
      $display("FAIL b2b_idle: idle cycles got %0d expected 2", idle);
    end
    bus1.send_packet = 1'b0;
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 90) begin
      fails++;
      $display("FAIL b2b_len2: got %0d (timeout %0d) expected 90", len, to);
    end
  endtask

  task automatic test_auto_repeat();
    int t0, t1, t2, t3, t4, d3, guard;
    bit to0, to1, to2, to3, to4;
    do_reset();
    bus1.car_sel = 2'd0;
    bus1.command = 4'b0000;
    bus1.repeat_en = 1'b1;
    next_start(t0, to0);
    next_start(t1, to1);
    next_start(t2, to2);
    bus1.command = 4'b1111;
    tests++;
    if (to0 || to1 || (t1 - t0) !== 100) begin
      fails++;
      $display("FAIL auto_interval1: got %0d expected 100", t1 - t0);
    end
    tests++;
    if (to2 || (t2 - t1) !== 100) begin
      fails++;
      $display("FAIL auto_interval2: got %0d expected 100", t2 - t1);
    end
    next_start(t3, to3);
    tests++;
    if (to3 || (t3 - t2) !== 100) begin
      fails++;
      $display("FAIL auto_interval3: got %0d expected 100", t3 - t2);
    end
    guard = 0;
    while (!bus1.done && guard < 500) begin step(); guard++; end
    d3 = cyc;
    tests++;
    if (guard >= 500 || (d3 - t3) !== 138) begin
      fails++;
      $display("FAIL auto_long_len: got %0d expected 138", d3 - t3);
    end
    next_start(t4, to4);
    tests++;
    if (to4 || (t4 - d3) !== 2) begin
      fails++;
      $display("FAIL auto_after_done: start-done got %0d expected 2", t4 - d3);
    end
    bus1.repeat_en = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    int len, rises, stray;
    logic [511:0] wave;
    bit to;
    do_reset();
    send_one1(0, 4'b1010);
    for (int r = 0; r < 26; r++) begin
      bus1.send_packet = (r == 5);
      step();
    end
    bus1.send_packet = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({bus1.ir_led, bus1.busy, bus1.done} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_outputs: ir,busy,done got %b expected 000", {bus1.ir_led, bus1.busy, bus1.done});
    end
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus1.busy || bus1.done) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL midrst_quiet: busy/done cycles got %0d expected 0", stray);
    end
    send_one1(0, 4'b1010);
    capture(len, rises, wave, to);
    tests++;
    if (to || len !== 114) begin
      fails++;
      $display("FAIL midrst_len: got %0d (timeout %0d) expected 114", len, to);
    end
    tests++;
    if (wave !== model_wave(0, 4'b1010)) begin
      fails++;
      $display("FAIL midrst_wave: got %h expected %h", wave, model_wave(0, 4'b1010));
    end
  endtask

  task automatic test_reject();
    int stray;
    bit to;
    do_reset();
    bus2.car_sel = 2'd1;
    bus2.command = 4'b0000;
    bus2.send_packet = 1'b1;
    step();
    bus2.send_packet = 1'b0;
    tests++;
    if ({bus2.busy, bus2.car_led} !== 4'b1010) begin
      fails++;
      $display("FAIL rej_valid_start: busy,car_led got %b expected 1010", {bus2.busy, bus2.car_led});
    end
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus2.done) begin
        to = 1'b0;
        break;
      end
      bus2.send_packet = (i == 5);
      if (i == 6) bus2.car_sel = 2'd3;
      step();
    end
    bus2.send_packet = 1'b0;
    step();
    step();
    tests++;
    if (to || {bus2.reject, bus2.busy, bus2.car_led} !== 5'b10010) begin
      fails++;
      $display("FAIL rej_pending: reject,busy,car_led got %b expected 10010 (timeout %0d)",
               {bus2.reject, bus2.busy, bus2.car_led}, to);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus2.busy || bus2.ir_led || bus2.reject) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL rej_quiet: active cycles got %0d expected 0", stray);
    end
    bus2.send_packet = 1'b1;
    step();
    bus2.send_packet = 1'b0;
    tests++;
    if ({bus2.reject, bus2.busy, bus2.ir_led, bus2.car_led} !== 6'b100010) begin
      fails++;
      $display("FAIL rej_direct: reject,busy,ir,car_led got %b expected 100010",
               {bus2.reject, bus2.busy, bus2.ir_led, bus2.car_led});
    end
    step();
    tests++;
    if ({bus2.reject, bus2.busy} !== 2'b00) begin
      fails++;
      $display("FAIL rej_pulse_width: reject,busy got %b expected 00", {bus2.reject, bus2.busy});
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.command = 4'b0000; bus1.car_sel = 2'd0; bus1.send_packet = 1'b0; bus1.repeat_en = 1'b0;
    bus2.command = 4'b0000; bus2.car_sel = 2'd0; bus2.send_packet = 1'b0; bus2.repeat_en = 1'b0;
    test_reset();
    test_single_packet();
    test_carrier_shape();
    test_pending_collapse();
    test_back_to_back();
    test_auto_repeat();
    test_reset_mid_packet();
    test_reject();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_packet_tx.md
# ir_packet_tx

Parametrised IR packet transmitter for the remote-car link. It is the next generation of the car transmitter state machine, sitting between the command/microprocessor logic and the IR LED pin. The block holds a per-car timing table of CAR_COUNT entries and supports an arbitrary command width. It adds a BUSY/DONE handshake, a one-deep pending request, auto-repeat at a programmable period, and rejection of invalid car indices.

## Interface
- CAR_COUNT, 4: number of car profiles; must be ≥ 2.
- CMD_LEN, 4: command bits sent per packet.
- CNT_W, 16: width of every timing-table entry.
- CARRIER_PERIOD, {2778,2667,2500,2778}: carrier period per car, in CLK cycles; packed CAR_COUNT×CNT_W; entry 0 is the LSB slice.
- START_PULSES, {192,88,88,191}: start burst length, in carrier periods.
- SELECT_PULSES, {24,44,22,47}: car-select burst length, in carrier periods.
- GAP_PULSES, {24,40,40,25}: gap length, in carrier periods.
- ASSERT_PULSES, {48,44,44,47}: burst length for a command bit = 1.
- DEASSERT_PULSES, {24,22,22,22}: burst length for a command bit = 0.
- REPEAT_PERIOD, 10_000_000: auto-repeat interval, in CLK cycles (10 Hz at 100 MHz); 32 bits.
- CLK  in  1  single clock, 100 MHz.
- RESET  in  1  reset; synchronous, active-high.
- COMMAND  in  CMD_LEN  command bits; sampled at packet start.
- CAR_SEL  in  $clog2(CAR_COUNT)  car index; sampled at packet start.
- SEND_PACKET  in  1  level-sampled request; each cycle it is high counts as a request.
- REPEAT_EN  in  1  enables auto-repeat.
- IR_LED  out  1  modulated IR output.
- BUSY  out  1  high while a packet is in flight.
- DONE  out  1  one-cycle pulse at packet end.
- REJECT  out  1  one-cycle pulse when a start is refused because CAR_SEL ≥ CAR_COUNT.
- CAR_LED  out  CAR_COUNT  one-hot of the latched car; holds after the packet ends.

## Operation
- States and transitions: IDLE → START → GAP_S → SELECT → GAP_C → BIT → BIT_GAP → (next bit ? BIT : IDLE).
- Bit order: COMMAND[CMD_LEN-1] first, down to COMMAND[0]. BIT length is ASSERT_PULSES if the bit is 1, DEASSERT_PULSES if it is 0. Every bit is followed by GAP_PULSES, including the last.
- Start trigger, evaluated only in IDLE, in priority order:
  - pending flag or SEND_PACKET high;
  - REPEAT_EN=1 and the repeat timer reaches REPEAT_PERIOD-1.
- On start:
  - latch COMMAND, CAR_SEL and that car's table entry;
  - clear the pending flag;
  - reset the carrier counter, pulse counter and repeat timer.
- Repeat timer: counts CLK cycles from the last packet start and saturates. If a packet outlasts REPEAT_PERIOD, the next auto packet starts in the first IDLE cycle.
- Pending request: SEND_PACKET seen while BUSY sets the pending flag. Several requests collapse into one; there is no queue beyond depth 1.
- Invalid car (CAR_SEL ≥ CAR_COUNT, possible only when CAR_COUNT is not a power of two):
  - no packet is sent and the state stays IDLE;
  - REJECT pulses;
  - the pending flag clears;
  - CAR_LED is unchanged.
- Carrier: per-packet counter 0..P-1, where P is the latched CARRIER_PERIOD. The carrier is high for counts < P/2 (floor).
- IR_LED = carrier high AND state ∈ {START, SELECT, BIT}. It is registered and is 0 in every gap and in IDLE.
- Phase advance: each phase lasts exactly its pulse count × P cycles. The pulse counter increments when the carrier counter wraps.
- Width rule: the carrier counter and pulse counter are CNT_W bits; the repeat timer is 32 bits.

## Timing
- Reset values: IR_LED=0, BUSY=0, DONE=0, REJECT=0, CAR_LED=0. State is IDLE, pending flag is 0, repeat timer is 0.
- RESET asserted mid-packet: IR_LED=0 at the next edge and the packet is aborted with no DONE. The pending request is dropped.
- Start latency:
  - request sampled at edge k;
  - BUSY=1 and IR_LED=1 from cycle k+1, carrier count 0;
  - CAR_LED is valid from cycle k+1.
- End of packet: with N total carrier periods, the packet occupies cycles k+1 .. k+N·P.
  - DONE=1 and BUSY=0 in cycle k+N·P+1.
  - A pending or auto start may begin in the cycle after DONE, never in the DONE cycle itself.
- Back-to-back requests: SEND_PACKET held high gives a continuous stream of packets with 2 idle cycles between them (DONE cycle + start cycle).
- N = START + GAP + SELECT + GAP + Σ(bit burst + GAP).

## Test plan
- Single packet: car 3 (P=2778, 191/25/47/25, assert 47 / deassert 22), COMMAND=4'b0101, one-cycle SEND_PACKET → N=526, DONE exactly 1,461,228 cycles after BUSY rises, 376 IR_LED rising edges, CAR_LED=4'b1000.
- Carrier shape: car 2 (P=2500) → IR_LED high 1250 cycles and low 1250 cycles within every burst period; constant 0 throughout every gap phase.
- Pending collapse: 3 SEND_PACKET pulses mid-packet, COMMAND changed to 4'b1010 before DONE → exactly one extra packet, sending 1010, starting the cycle after DONE.
- Auto-repeat: REPEAT_EN=1, REPEAT_PERIOD overridden to 2,000,000, car 0 → packet starts at 2,000,000-cycle intervals. Then override to 1,000,000 → each new start occurs exactly 1 cycle after the previous DONE.
- Reject: CAR_COUNT=3 build, CAR_SEL=3 → one REJECT pulse, BUSY stays 0, no IR_LED activity.
- Reset mid-packet: RESET during SELECT → IR_LED=0 and BUSY=0 at the next edge, no DONE; a fresh request afterwards gives a full packet of normal length.
